// File: rtl/srl_delay_pkg.sv
// srl_delay_pkg
//   Shared limits and the elaboration-time parameter check used by the
//   srl_delay_line delay-line slice.
package srl_delay_pkg;

    localparam int DEPTH_MIN = 2;
    localparam int DEPTH_MAX = 1024;
    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 64;

    // True when WIDTH is in range and DEPTH is an in-range power of two.
    function automatic bit srl_delay_params_ok(input int width, input int depth);
        bit width_ok;
        bit depth_ok;
        width_ok = (width >= WIDTH_MIN) && (width <= WIDTH_MAX);
        depth_ok = (depth >= DEPTH_MIN) && (depth <= DEPTH_MAX) &&
                   ((depth & (depth - 1)) == 0);
        return width_ok && depth_ok;
    endfunction

endpackage

// File: rtl/srl_delay_lane.sv
// srl_delay_lane
//   One-bit, DEPTH-deep shift register with a variable read tap.
//   Written without reset so synthesis maps it onto SRL primitives.
// Ports:
//   CLK    - clock, shifts on rising edge
//   CE     - shift enable
//   D      - bit shifted into stage 0
//   A      - tap select, 0 = newest stage
//   Q      - bit at stage A
//   Q_LAST - bit at stage DEPTH-1
module srl_delay_lane
    import srl_delay_pkg::*;
#(
    parameter int   DEPTH    = 32,
    parameter int   AW       = $clog2(DEPTH),
    parameter logic INIT_BIT = 1'b0
) (
    input  logic          CLK,
    input  logic          CE,
    input  logic          D,
    input  logic [AW-1:0] A,
    output logic          Q,
    output logic          Q_LAST
);

    // Power-up value only; no reset touches the storage.
    logic [DEPTH-1:0] sr = {DEPTH{INIT_BIT}};

    always_ff @(posedge CLK) begin
        if (CE) begin
            sr <= {sr[DEPTH-2:0], D};
        end
    end

    assign Q      = sr[A];
    assign Q_LAST = sr[DEPTH-1];

endmodule

// File: rtl/srl_delay_line.sv
// srl_delay_line
//   WIDTH-lane, DEPTH-stage variable-tap delay line with a saturating fill
//   counter that qualifies the tap output.
// Ports:
//   CLK     - clock
//   RST_N   - synchronous active-low reset (fill counter / output regs only)
//   CE      - shift enable
//   FLUSH   - clear fill counter, stage data retained
//   D       - input sample
//   A       - tap select, 0 = newest, DEPTH-1 = oldest
//   Q       - sample at tap A
//   Q_VALID - tap A holds a sample written since last reset/flush
//   Q_LAST  - sample at stage DEPTH-1
//   FULL    - fill counter equals DEPTH
// Configuration:
//   SRL_DELAY_OREG_EN - when defined, Q/Q_VALID/Q_LAST/FULL are registered
//                       once (free-running, cleared by RST_N).
module srl_delay_line
    import srl_delay_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter int               DEPTH = 32,
    parameter int               AW    = $clog2(DEPTH),
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CE,
    input  logic             FLUSH,
    input  logic [WIDTH-1:0] D,
    input  logic [AW-1:0]    A,
    output logic [WIDTH-1:0] Q,
    output logic             Q_VALID,
    output logic [WIDTH-1:0] Q_LAST,
    output logic             FULL
);

    localparam int          CW      = AW + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    if (!srl_delay_params_ok(WIDTH, DEPTH)) begin : g_bad_params
        $error("srl_delay_line: WIDTH must be 1..64 and DEPTH a power of two in 2..1024");
    end
    if (AW != $clog2(DEPTH)) begin : g_bad_aw
        $error("srl_delay_line: AW is derived from DEPTH and must not be overridden");
    end

    logic [WIDTH-1:0] tap_q;
    logic [WIDTH-1:0] tap_last;
    logic             tap_valid;
    logic             tap_full;
    logic [CW-1:0]    cnt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        srl_delay_lane #(
            .DEPTH    (DEPTH),
            .AW       (AW),
            .INIT_BIT (INIT[i])
        ) u_lane (
            .CLK    (CLK),
            .CE     (CE),
            .D      (D[i]),
            .A      (A),
            .Q      (tap_q[i]),
            .Q_LAST (tap_last[i])
        );
    end

    // Reset beats flush, flush beats saturation; a flush with CE counts
    // the sample written on that same edge.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt <= '0;
        end else if (FLUSH) begin
            cnt <= CE ? CNT_ONE : '0;
        end else if (CE && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_ONE;
        end
    end

    always_comb begin
        tap_valid = (cnt > {1'b0, A});
        tap_full  = (cnt == CNT_MAX);
    end

`ifdef SRL_DELAY_OREG_EN
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            Q       <= '0;
            Q_VALID <= 1'b0;
            Q_LAST  <= '0;
            FULL    <= 1'b0;
        end else begin
            Q       <= tap_q;
            Q_VALID <= tap_valid;
            Q_LAST  <= tap_last;
            FULL    <= tap_full;
        end
    end
`else
    always_comb begin
        Q       = tap_q;
        Q_VALID = tap_valid;
        Q_LAST  = tap_last;
        FULL    = tap_full;
    end
`endif

endmodule

// File: tb/tb_srl_delay_line.sv
module tb_srl_delay_line;

    localparam int          WIDTH = 16;
    localparam int          DEPTH = 32;
    localparam int          AW    = 5;
    localparam logic [15:0] INITV = 16'hA5A5;

    logic             CLK = 1'b0;
    logic             RST_N;
    logic             CE;
    logic             FLUSH;
    logic [WIDTH-1:0] D;
    logic [AW-1:0]    A;
    logic [WIDTH-1:0] Q;
    logic             Q_VALID;
    logic [WIDTH-1:0] Q_LAST;
    logic             FULL;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        bit          chk_q;
        logic [15:0] q;
        logic        valid;
        logic        full;
        bit          chk_last;
        logic [15:0] qlast;
    } exp_t;

    exp_t sb[$];

    srl_delay_line #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .INIT  (INITV)
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .CE      (CE),
        .FLUSH   (FLUSH),
        .D       (D),
        .A       (A),
        .Q       (Q),
        .Q_VALID (Q_VALID),
        .Q_LAST  (Q_LAST),
        .FULL    (FULL)
    );

    always #5 CLK = ~CLK;

    // Monitor: outputs are settled mid-cycle; pop and compare everything
    // the stimulus queued for this cycle.
    always @(negedge CLK) begin
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if (Q_VALID !== e.valid) begin
                bad++;
                $display("FAIL %s q_valid: got %b want %b (A=%0d)", e.name, Q_VALID, e.valid, A);
            end
            total++;
            if (FULL !== e.full) begin
                bad++;
                $display("FAIL %s full: got %b want %b", e.name, FULL, e.full);
            end
            if (e.chk_q) begin
                total++;
                if (Q !== e.q) begin
                    bad++;
                    $display("FAIL %s q: got %h want %h (A=%0d)", e.name, Q, e.q, A);
                end
            end
            if (e.chk_last) begin
                total++;
                if (Q_LAST !== e.qlast) begin
                    bad++;
                    $display("FAIL %s q_last: got %h want %h", e.name, Q_LAST, e.qlast);
                end
            end
        end
    end

    task automatic tick(input logic ce_i, input logic fl_i, input logic rn_i, input logic [15:0] d_i);
        CE    = ce_i;
        FLUSH = fl_i;
        RST_N = rn_i;
        D     = d_i;
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_out(input string name, input bit chk_q, input logic [15:0] q,
                              input logic valid, input logic full,
                              input bit chk_last, input logic [15:0] qlast);
        exp_t e;
        e.name = name; e.chk_q = chk_q; e.q = q; e.valid = valid;
        e.full = full; e.chk_last = chk_last; e.qlast = qlast;
        sb.push_back(e);
    endtask

    initial begin
        int m;
        A = '0;
        // Power-up / reset: storage still holds INIT everywhere.
        tick(1'b0, 1'b0, 1'b0, 16'h0);
        A = 5'd0;
        expect_out("reset", 1'b1, INITV, 1'b0, 1'b0, 1'b1, INITV);

        // Basic delay, A=5, D = edge number.
        tick(1'b0, 1'b0, 1'b0, 16'h0);
        A = 5'd5;
        for (int n = 1; n <= 12; n++) begin
            tick(1'b1, 1'b0, 1'b1, 16'(n));
            expect_out("basic", 1'b1, (n >= 6) ? 16'(n - 5) : INITV,
                       (n >= 6), 1'b0, 1'b0, 16'h0);
        end

        // CE gating: CE high on odd clocks only.
        tick(1'b0, 1'b0, 1'b0, 16'h0);
        for (int k = 1; k <= 14; k++) begin
            tick((k % 2) == 1, 1'b0, 1'b1, 16'(k));
            m = (k + 1) / 2;
            expect_out("ce_gate", (m >= 6), 16'(2 * (m - 5) - 1),
                       (m >= 6), 1'b0, 1'b0, 16'h0);
        end

        // Saturation: 40 CE edges, tap 31.
        tick(1'b0, 1'b0, 1'b0, 16'h0);
        A = 5'd31;
        for (int n = 1; n <= 40; n++) begin
            tick(1'b1, 1'b0, 1'b1, 16'(100 + n));
            expect_out("satur", (n >= 32), 16'(100 + n - 31),
                       (n >= 32), (n >= 32), (n >= 32), 16'(100 + n - 31));
        end

        // Flush together with CE: counter restarts at 1.
        tick(1'b1, 1'b1, 1'b1, 16'hBEEF);
        A = 5'd0;
        expect_out("flush_a0", 1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0, 16'h0);
        tick(1'b0, 1'b0, 1'b1, 16'h0);
        A = 5'd1;
        expect_out("flush_a1", 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
        tick(1'b0, 1'b0, 1'b1, 16'h0);
        A = 5'd3;
        expect_out("flush_old", 1'b1, 16'd138, 1'b0, 1'b0, 1'b0, 16'h0);

        // Reset mid-run after 20 CEs.
        tick(1'b0, 1'b0, 1'b0, 16'h0);
        A = 5'd0;
        for (int n = 1; n <= 20; n++) begin
            tick(1'b1, 1'b0, 1'b1, 16'(200 + n));
        end
        A = 5'd19;
        expect_out("fill20_a19", 1'b1, 16'd201, 1'b1, 1'b0, 1'b0, 16'h0);
        tick(1'b0, 1'b0, 1'b1, 16'h0);
        A = 5'd20;
        expect_out("fill20_a20", 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
        tick(1'b0, 1'b0, 1'b0, 16'h0);
        A = 5'd0;
        expect_out("midrst", 1'b1, 16'd220, 1'b0, 1'b0, 1'b0, 16'h0);
        tick(1'b1, 1'b0, 1'b1, 16'd300);
        expect_out("refill_a0", 1'b1, 16'd300, 1'b1, 1'b0, 1'b0, 16'h0);
        tick(1'b0, 1'b0, 1'b1, 16'h0);
        A = 5'd1;
        expect_out("refill_a1", 1'b1, 16'd220, 1'b0, 1'b0, 1'b0, 16'h0);

        @(negedge CLK);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/srl_delay_line.md
# srl_delay_line

Parametrised, multi-lane, variable-tap shift-register delay line with fill tracking. It generalises the single-bit 32-deep SRL primitive to WIDTH bits and DEPTH stages. A fill counter qualifies the tap output, so consumers see Q_VALID only once the selected tap holds real samples. The block sits in DSP and sample-alignment paths, such as per-channel skew compensation and pipeline matching, and maps onto SRL fabric primitives.

## Interface
Parameters:
- WIDTH, 16: data bits per sample (1..64).
- DEPTH, 32: number of stages. Must be a power of two, 2..1024.
- AW, $clog2(DEPTH): tap address width. Derived; not to be overridden.
- INIT, 0: simulation/configuration initial value of every stage (WIDTH bits).

Ports:
- CLK, in, 1: single clock; all state updates on its rising edge.
- RST_N, in, 1: reset, synchronous, active-low.
- CE, in, 1: shift enable.
- FLUSH, in, 1: synchronous clear of the fill counter; stage data is retained.
- D, in, WIDTH: sample shifted in when CE=1.
- A, in, AW: tap select. 0 selects the newest sample; DEPTH-1 selects the oldest.
- Q, out, WIDTH: sample at tap A.
- Q_VALID, out, 1: tap A holds a sample written since the last reset or flush.
- Q_LAST, out, WIDTH: sample at stage DEPTH-1 (cascade output).
- FULL, out, 1: fill counter equals DEPTH.

## Operation
- Storage is mem[0..DEPTH-1] per lane. On CE=1: mem[0] <= D and mem[i] <= mem[i-1]. On CE=0 the storage holds.
- Storage has no reset, so that it maps to SRL primitives. It powers up as INIT, and RST_N and FLUSH leave its contents unchanged.
- Fill counter cnt has width AW+1 and range 0..DEPTH:
  - RST_N=0: cnt <= 0.
  - Otherwise, FLUSH=1 and CE=1: cnt <= 1. The sample written this cycle is counted.
  - FLUSH=1 and CE=0: cnt <= 0.
  - CE=1 alone: cnt <= min(cnt+1, DEPTH). Saturates; never wraps.
- Q = mem[A]; Q_LAST = mem[DEPTH-1]; Q_VALID = (cnt > A); FULL = (cnt == DEPTH).
- A may change on any cycle. Q and Q_VALID follow the new A with no extra delay and no re-fill penalty.
- Reset mid-operation: Q_VALID and FULL drop. Q continues to show the retained stage data, which consumers must ignore while Q_VALID=0.
- RST_N has priority over FLUSH, and FLUSH has priority over saturation.

## Timing
- Write-to-tap latency: a sample presented with CE=1 at edge n appears at Q after edge n when A=0. It reaches tap k after k further CE edges.
- In the base configuration Q, Q_VALID, Q_LAST and FULL are combinational from A and the state registers. They have zero cycles from A.
- Reset values: cnt=0, Q_VALID=0, FULL=0. Q and Q_LAST equal INIT after power-up and are undefined-but-stable after a mid-run reset.
- Q_VALID for tap A rises on the edge where the (A+1)-th CE since reset/flush occurs.

## Configuration
- SRL_DELAY_OREG_EN defined: Q, Q_VALID, Q_LAST and FULL are each registered once.
  - Registers update every cycle, not gated by CE.
  - RST_N=0 clears all four registers to 0.
  - All latencies, including A-to-Q, grow by exactly one cycle.
- SRL_DELAY_OREG_EN undefined: the outputs are combinational, as described above. No output registers exist.

## Structure
- Package srl_delay_pkg holds:
  - the limit constants DEPTH_MIN=2 and DEPTH_MAX=1024;
  - an elaboration check function that rejects a non-power-of-two DEPTH or an out-of-range WIDTH.
- Sub-module srl_delay_lane is one bit wide and DEPTH deep, with CE, D, A, Q and Q_LAST. It is instantiated WIDTH times via generate, so synthesis infers SRLs per bit.
- The fill counter and output registers live only in the top level.

## Test plan
- Basic delay: WIDTH=16, DEPTH=32, A=5, CE=1 constantly, D=1,2,3,…
  - Q_VALID rises on the 6th edge.
  - From then on, Q equals D minus 5 (D-5).
- CE gating: same setup with CE toggled 1,0,1,0.
  - Q and cnt advance only on CE=1 edges.
  - Q_VALID rises after 6 CE-high edges, i.e. 11 clocks.
- Saturation and FULL: 40 CE edges at DEPTH=32.
  - FULL=1 from edge 32 onward and cnt stays 32.
  - A=31 gives Q == Q_LAST == the sample from edge 9.
- Flush with CE: with FULL, assert FLUSH=1 and CE=1 for one cycle.
  - Next cycle: cnt=1, Q_VALID=1 for A=0 and 0 for A=1.
  - Q for A=3 shows the old retained data.
- Reset mid-run: RST_N=0 for 1 cycle after 20 CEs.
  - Q_VALID=0 and FULL=0.
  - Storage is retained: A=0 still shows the last D.
  - Refill restarts from cnt=0.
- Dynamic tap plus OREG: with SRL_DELAY_OREG_EN, sweep A 0→31 once per cycle on a full line.
  - Q matches the combinational model delayed by exactly 1 cycle.
  - All outputs read 0 in the cycle after reset.
